display_router: RTL and testbench

//   Parametrised successor to the op_code display mux in the pseudo-terminal.

---
 rtl/display_router_if.sv | 23 ++
 rtl/display_router.sv | 162 ++++++++++++++++
 tb/tb_display_router.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/display_router_if.sv
// display_router_if - bundles the channel-select / display bus of display_router.
//   op_code   : one-hot channel select (NUM_CH bits)
//   disp_in   : NUM_CH packed display words, channel k at [k*DIGITS*5 +: DIGITS*5]
//   display   : registered display word, digit d at [d*5 +: 5]
//   sel_valid : high only while a channel is being shown
//   sel_idx   : index of the last accepted channel
// Modports: master drives op_code/disp_in, slave (the router) drives the outputs.
interface display_router_if #(
  parameter int NUM_CH = 11,
  parameter int DIGITS = 8
);
  localparam int W     = DIGITS * 5;
  localparam int IDX_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]   op_code;
  logic [NUM_CH*W-1:0] disp_in;
  logic [W-1:0]        display;
  logic                sel_valid;
  logic [IDX_W-1:0]    sel_idx;

  modport master (output op_code, disp_in, input display, sel_valid, sel_idx);
  modport slave  (input op_code, disp_in, output display, sel_valid, sel_idx);
endinterface

// File: rtl/display_router.sv
// display_router - routes one of NUM_CH 7-seg source words to a shared display.
//   An op_code change blanks the display and must stay stable for SETTLE_CYCLES
//   edges before it is accepted. A one-hot code shows that channel (registered,
//   1-cycle latency from disp_in); a zero or multi-hot code shows the "Err" word.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : display_router_if.slave (op_code, disp_in in; display, sel_valid, sel_idx out)
// Optional feature macro: DISPLAY_ROUTER_BLINK_EN
//   Defined  : the Err word blinks (Err / blank) with half-period BLINK_CYCLES.
//   Undefined: steady Err word, no blink counter, BLINK_CYCLES unused.
module display_router #(
  parameter int NUM_CH        = 11,
  parameter int DIGITS        = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_POS       = 3,
  parameter int BLINK_CYCLES  = 50000000
) (
  input logic             clk,
  input logic             reset,
  display_router_if.slave bus
);
  localparam int W     = DIGITS * 5;
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [W-1:0] BLANK_WORD = '1;

  function automatic logic [W-1:0] mk_err_word();
    logic [W-1:0] w;
    w = '1;
    w[(ERR_POS+2)*5 +: 5] = 5'b01011;
    w[(ERR_POS+1)*5 +: 5] = 5'b01010;
    w[ERR_POS*5     +: 5] = 5'b01101;
    return w;
  endfunction

  localparam logic [W-1:0] ERR_WORD = mk_err_word();

  typedef enum logic [1:0] {SETTLE, SHOW, ERR} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_CH-1:0] op_q;
  logic [W-1:0]     display_q, display_n;
  logic             sel_valid_q, sel_valid_n;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_n;

  logic             chg;
  logic             op_onehot;
  logic [IDX_W-1:0] op_idx, slice_idx;
  logic [W-1:0]     slice;

  assign chg       = (bus.op_code != op_q);
  assign op_onehot = $onehot(op_q);

  always_comb begin
    op_idx = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (op_q[k]) op_idx = IDX_W'(k);
  end

  // In SHOW the accepted index drives the mux; on SHOW entry it is the index
  // being accepted this edge.
  assign slice_idx = (state == SHOW) ? sel_idx_q : op_idx;

  always_comb begin
    slice = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (IDX_W'(k) == slice_idx) slice = bus.disp_in[k*W +: W];
  end

`ifdef DISPLAY_ROUTER_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
  logic               blink_ph, blink_ph_n;  // 1 = blank half of the blink
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    display_n   = display_q;
    sel_valid_n = sel_valid_q;
    sel_idx_n   = sel_idx_q;
`ifdef DISPLAY_ROUTER_BLINK_EN
    blink_cnt_n = blink_cnt;
    blink_ph_n  = blink_ph;
`endif
    if (chg) begin
      // Any op_code change restarts the settle window, whatever the state.
      state_n     = SETTLE;
      cnt_n       = '0;
      display_n   = BLANK_WORD;
      sel_valid_n = 1'b0;
    end else begin
      unique case (state)
        SETTLE: begin
          if (cnt < CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt_n = cnt + 1'b1;
          end else if (op_onehot) begin
            state_n     = SHOW;
            sel_idx_n   = op_idx;
            display_n   = slice;
            sel_valid_n = 1'b1;
          end else begin
            state_n   = ERR;
            display_n = ERR_WORD;
`ifdef DISPLAY_ROUTER_BLINK_EN
            blink_cnt_n = '0;
            blink_ph_n  = 1'b0;
`endif
          end
        end
        SHOW: display_n = slice;
        ERR: begin
`ifdef DISPLAY_ROUTER_BLINK_EN
          if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_n = '0;
            blink_ph_n  = ~blink_ph;
          end else begin
            blink_cnt_n = blink_cnt + 1'b1;
          end
          display_n = blink_ph_n ? BLANK_WORD : ERR_WORD;
`else
          display_n = ERR_WORD;
`endif
        end
        default: state_n = SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SETTLE;
      cnt         <= '0;
      op_q        <= '0;
      display_q   <= BLANK_WORD;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
`ifdef DISPLAY_ROUTER_BLINK_EN
      blink_cnt   <= '0;
      blink_ph    <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      op_q        <= bus.op_code;
      display_q   <= display_n;
      sel_valid_q <= sel_valid_n;
      sel_idx_q   <= sel_idx_n;
`ifdef DISPLAY_ROUTER_BLINK_EN
      blink_cnt   <= blink_cnt_n;
      blink_ph    <= blink_ph_n;
`endif
    end
  end

  assign bus.display   = display_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.sel_idx   = sel_idx_q;
endmodule

// File: tb/tb_display_router.sv
// tb_display_router - randomized self-checking bench for display_router.
//   The reference model tracks "edges since op_code last changed"; once that
//   age reaches SETTLE_CYCLES the expected output follows from whether op_code
//   is one-hot. Every edge is compared; a few literal checks pin the model.
module tb_display_router;
  localparam int NUM_CH = 11;
  localparam int DIGITS = 8;
  localparam int SETTLE = 4;
  localparam int W      = DIGITS * 5;
  localparam int IDX_W  = $clog2(NUM_CH);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  display_router_if #(.NUM_CH(NUM_CH), .DIGITS(DIGITS)) bus ();

  display_router #(
    .NUM_CH(NUM_CH), .DIGITS(DIGITS), .SETTLE_CYCLES(SETTLE), .ERR_POS(3), .BLINK_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [NUM_CH-1:0] m_prev;
  int                m_age;
  logic [IDX_W-1:0]  m_idx;
  logic [W-1:0]      e_disp;
  logic              e_valid;

  function automatic logic [W-1:0] err_word();
    logic [W-1:0] w;
    w = '1;
    w[5*5 +: 5] = 5'b01011;  // 'E'
    w[4*5 +: 5] = 5'b01010;  // 'r'
    w[3*5 +: 5] = 5'b01101;  // 'r'
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then
  // compare all outputs shortly after.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_prev  = '0;
      m_age   = 0;
      m_idx   = '0;
      e_disp  = '1;
      e_valid = 1'b0;
    end else begin
      if (bus.op_code != m_prev) m_age = 0;
      else if (m_age < SETTLE) m_age++;
      m_prev = bus.op_code;
      if (m_age < SETTLE) begin
        e_disp  = '1;
        e_valid = 1'b0;
      end else if ($countones(bus.op_code) == 1) begin
        for (int k = 0; k < NUM_CH; k++)
          if (bus.op_code[k]) m_idx = IDX_W'(k);
        e_disp  = bus.disp_in[int'(m_idx)*W +: W];
        e_valid = 1'b1;
      end else begin
        e_disp  = err_word();
        e_valid = 1'b0;
      end
    end
    #1;
    chk("display",   64'(bus.display),   64'(e_disp));
    chk("sel_valid", 64'(bus.sel_valid), 64'(e_valid));
    chk("sel_idx",   64'(bus.sel_idx),   64'(m_idx));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rand_disp();
    for (int k = 0; k < NUM_CH * DIGITS; k++)
      bus.disp_in[k*5 +: 5] = 5'($urandom);
  endtask

  initial begin
    int r;
    reset       = 1'b1;
    bus.op_code = '0;
    rand_disp();

    // 1: reset with op_code=0, then ERR after 4 edges
    ticks(2);
    chk("reset_display_lit", 64'(bus.display), 64'h00_FFFFFFFFFF);
    reset = 1'b0;
    ticks(3);
    chk("pre_err_blank_lit", 64'(bus.display), 64'h00_FFFFFFFFFF);
    tick();
    chk("err_word_lit", 64'(bus.display), 64'h00_FFD6A6FFFF);
    chk("err_valid_lit", 64'(bus.sel_valid), 64'd0);

    // 2: select channel 2
    bus.disp_in[2*W +: W] = 40'h0123456789;
    bus.op_code = 11'h004;
    ticks(4);
    chk("settle_blank_lit", 64'(bus.display), 64'h00_FFFFFFFFFF);
    tick();
    chk("show_lit", 64'(bus.display), 64'h00_0123456789);
    chk("show_idx_lit", 64'(bus.sel_idx), 64'd2);
    bus.disp_in[2*W +: W] = 40'h00AABBCCDD;
    tick();
    chk("show_follow_lit", 64'(bus.display), 64'h00_00AABBCCDD);

    // 3: glitch to ch0 for 2 cycles, back to ch2
    bus.op_code = 11'h001;
    tick();
    chk("glitch_blank_lit", 64'(bus.sel_valid), 64'd0);
    tick();
    bus.op_code = 11'h004;
    ticks(4);
    chk("glitch_still_blank_lit", 64'(bus.sel_valid), 64'd0);
    tick();
    chk("resume_idx_lit", 64'(bus.sel_idx), 64'd2);
    chk("resume_valid_lit", 64'(bus.sel_valid), 64'd1);

    // 4: multi-hot -> ERR, sel_idx holds
    bus.op_code = 11'h005;
    ticks(5);
    chk("multihot_err_lit", 64'(bus.display), 64'h00_FFD6A6FFFF);
    chk("multihot_idx_lit", 64'(bus.sel_idx), 64'd2);

    // 5: reset together with a change while in SHOW
    bus.op_code = 11'h400;
    ticks(6);
    bus.op_code = 11'h008;
    reset = 1'b1;
    tick();
    chk("reset_wins_idx_lit", 64'(bus.sel_idx), 64'd0);
    chk("reset_wins_disp_lit", 64'(bus.display), 64'h00_FFFFFFFFFF);
    reset = 1'b0;
    ticks(5);
    chk("recover_valid_lit", 64'(bus.sel_valid), 64'd1);
    chk("recover_idx_lit", 64'(bus.sel_idx), 64'd3);

    // randomized phase
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 99);
      if (r < 6)       bus.op_code = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
      else if (r < 8)  bus.op_code = '0;
      else if (r < 10) bus.op_code = NUM_CH'($urandom);
      else if (r < 13) bus.op_code = bus.op_code ^ (NUM_CH'(1) << $urandom_range(0, NUM_CH - 1));
      if ($urandom_range(0, 9) < 3) rand_disp();
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
